kypd_scanner: RTL and testbench

Input-side counterpart of the Nexys A7 seven-segment display driver. It scans a 4x4 matrix keypad (Pmod KYPD) one column at a time, debounces what it reads, and emits one event per key press. It also outputs the last accepted key as a 6-bit digit word `{enable, hex[3:0], dp}`, the same format the display driver consumes, so it can feed a display input directly.

---
 rtl/kypd_scanner_pkg.sv | 23 ++
 rtl/kypd_scanner_if.sv | 21 ++
 rtl/kypd_scanner_tick_gen.sv | 26 ++
 rtl/kypd_scanner.sv | 159 +++++++++++++++
 tb/tb_kypd_scanner.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/kypd_scanner_pkg.sv
// Shared types and constants for the Pmod KYPD scanner and the seven-segment display side.
package kypd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } kypd_state_e;

  // Indexed by {row, col}; rows top to bottom, columns left to right.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic [5:0] pack_digit(input logic en, input logic [3:0] hex, input logic dp);
    return {en, hex, dp};
  endfunction

endpackage

// File: rtl/kypd_scanner_if.sv
// Keypad pins plus the decoded key outputs; master is the scanner, slave is the pad/consumer side.
interface kypd_scanner_if;

  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [5:0] digit;

  modport master (
    output col, key_valid, key_code, key_held, digit,
    input  row
  );

  modport slave (
    input  col, key_valid, key_code, key_held, digit,
    output row
  );

endinterface

// File: rtl/kypd_scanner_tick_gen.sv
// Free-running slot timer; tick is high for one cycle every TICK_CYCLES clocks.
module tick_gen #(
  parameter int TICK_CYCLES = 100_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset)
      count <= '0;
    else if (tick)
      count <= '0;
    else
      count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/kypd_scanner.sv
// 4x4 keypad scanner: column scan, per-frame classification, debounced press/release events.
module kypd_scanner
  import kypd_pkg::*;
#(
  parameter int TICK_CYCLES     = 100_000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic            clock,
  input  logic            reset,
  kypd_scanner_if.master  kp
);

  localparam logic [4:0] DF     = 5'(DEBOUNCE_FRAMES);
  localparam bit         DF_ONE = (DEBOUNCE_FRAMES == 1);

  logic        tick;
  logic [1:0]  col_idx;
  logic [3:0]  row_meta, row_sync;
  logic [15:0] frame_acc, frame_now;
  logic [4:0]  hits;
  logic [3:0]  hit_idx;
  logic        frame_end, is_empty, is_single;
  logic [3:0]  key_now;

  kypd_state_e state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [4:0]  cnt_inc;
  logic [3:0]  cand, cand_n;
  logic [3:0]  key_code_r, code_n;
  logic        digit_en, en_n;
  logic        key_valid_r, valid_n;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Current column's live rows merged into the frame so the column-3 tick sees the whole frame.
  always_comb begin
    frame_now = frame_acc;
    for (int r = 0; r < 4; r++)
      frame_now[{2'(r), col_idx}] = ~row_sync[r];
  end

  always_comb begin
    hits    = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_now[i]) begin
        hits    = hits + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign frame_end = tick && (col_idx == 2'd3);
  assign is_empty  = (hits == 5'd0);
  assign is_single = (hits == 5'd1);
  assign key_now   = KEY_MAP[hit_idx];
  assign cnt_inc   = {1'b0, cnt} + 5'd1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = key_code_r;
    en_n    = digit_en;
    valid_n = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (is_single) begin
            cand_n = key_now;
            cnt_n  = 4'd1;
            if (DF_ONE) begin
              code_n  = key_now;
              en_n    = 1'b1;
              valid_n = 1'b1;
              state_n = HELD;
            end else begin
              state_n = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (is_single && key_now == cand) begin
            if (cnt_inc >= DF) begin
              code_n  = cand;
              en_n    = 1'b1;
              valid_n = 1'b1;
              state_n = HELD;
            end else begin
              cnt_n = cnt_inc[3:0];
            end
          end else if (is_single) begin
            cand_n = key_now;
            cnt_n  = 4'd1;
          end else begin
            state_n = IDLE;
          end
        end
        // A held pad must go fully empty before any new key can be debounced.
        HELD: begin
          if (is_empty) begin
            cnt_n   = 4'd1;
            state_n = DF_ONE ? IDLE : REL_DB;
          end
        end
        REL_DB: begin
          if (is_empty) begin
            if (cnt_inc >= DF)
              state_n = IDLE;
            else
              cnt_n = cnt_inc[3:0];
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      col_idx     <= 2'd0;
      row_meta    <= 4'hF;
      row_sync    <= 4'hF;
      frame_acc   <= '0;
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_code_r  <= '0;
      digit_en    <= 1'b0;
      key_valid_r <= 1'b0;
    end else begin
      row_meta    <= kp.row;
      row_sync    <= row_meta;
      if (tick) begin
        col_idx   <= col_idx + 2'd1;
        frame_acc <= frame_now;
      end
      state       <= state_n;
      cnt         <= cnt_n;
      cand        <= cand_n;
      key_code_r  <= code_n;
      digit_en    <= en_n;
      key_valid_r <= valid_n;
    end
  end

  assign kp.col       = ~(4'b0001 << col_idx);
  assign kp.key_valid = key_valid_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_held  = (state == HELD) || (state == REL_DB);
  assign kp.digit     = pack_digit(digit_en, key_code_r, 1'b0);

endmodule

// File: tb/tb_kypd_scanner.sv
// Self-checking bench: a physical keypad model drives the rows, a frame-level debounce model predicts events.
module tb_kypd_scanner;

  localparam int TICKS = 10;
  localparam int DF    = 3;
  localparam int FRAME = 4 * TICKS;

  localparam logic [3:0] TB_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] key_mask = '0;
  int          checks = 0;
  int          errors = 0;

  int          m_run, m_erun;
  logic [3:0]  m_cand, m_code;
  logic        m_en, m_held;

  kypd_scanner_if kif();

  // Pressed switches short the driven (low) column onto their row.
  function automatic logic [3:0] pad_rows(input logic [3:0] c, input logic [15:0] m);
    logic [3:0] res;
    res = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (!c[cc] && m[r*4 + cc]) res[r] = 1'b0;
    return res;
  endfunction

  assign kif.row = pad_rows(kif.col, key_mask);

  kypd_scanner #(.TICK_CYCLES(TICKS), .DEBOUNCE_FRAMES(DF)) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kif.master)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_erun = 0; m_cand = '0; m_code = '0; m_en = 1'b0; m_held = 1'b0;
  endfunction

  // Press accepted after DF consecutive frames showing the same lone key; release after DF empty frames.
  function automatic int model_frame(input logic [15:0] m);
    int n, idx, pulse;
    n = $countones(m);
    idx = 0;
    pulse = 0;
    for (int i = 0; i < 16; i++) if (m[i]) idx = i;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && TB_MAP[idx] == m_cand) m_run++;
        else begin m_cand = TB_MAP[idx]; m_run = 1; end
        if (m_run == DF) begin
          m_code = m_cand; m_en = 1'b1; m_held = 1'b1; m_run = 0; m_erun = 0; pulse = 1;
        end
      end else m_run = 0;
    end else begin
      if (n == 0) begin
        m_erun++;
        if (m_erun == DF) begin m_held = 1'b0; m_erun = 0; end
      end else m_erun = 0;
    end
    return pulse;
  endfunction

  function automatic logic [3:0] exp_col(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((k / TICKS) % 4));
  endfunction

  task automatic checkState(input string tag, input int pulses, input int exp_pulses);
    checkOutput({tag, ":pulses"}, 32'(pulses), 32'(exp_pulses));
    checkOutput({tag, ":code"}, 32'(kif.key_code), 32'(m_code));
    checkOutput({tag, ":held"}, 32'(kif.key_held), 32'(m_held));
    checkOutput({tag, ":digit"}, 32'(kif.digit), 32'({m_en, m_code, 1'b0}));
  endtask

  // One full frame with a constant set of pressed keys, starting right after a frame boundary.
  task automatic applyStimulus(input logic [15:0] mask, input string tag);
    int pulses, exp_pulses;
    pulses = 0;
    key_mask = mask;
    exp_pulses = model_frame(mask);
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clock); #1;
      if (kif.key_valid) pulses++;
      if (k % TICKS == 5) checkOutput({tag, ":col"}, 32'(kif.col), 32'(exp_col(k)));
    end
    checkState(tag, pulses, exp_pulses);
  endtask

  task automatic resetMid(input logic [15:0] mask, input int cyc);
    int pulses;
    pulses = 0;
    key_mask = mask;
    for (int k = 0; k < cyc; k++) begin
      @(posedge clock); #1;
      if (kif.key_valid) pulses++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if (kif.key_valid) pulses++;
    end
    model_reset();
    checkOutput("rstmid:col", 32'(kif.col), 32'(4'b1110));
    checkState("rstmid", pulses, 0);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] rmask;
    int kind, len, b1, b2;
    model_reset();
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("reset:col", 32'(kif.col), 32'(4'b1110));
    checkOutput("reset:valid", 32'(kif.key_valid), 32'(0));
    checkState("reset", 0, 0);
    reset = 1'b1;

    repeat (4) applyStimulus(16'h0000, "idle");

    repeat (6) applyStimulus(16'h0020, "key5");
    repeat (3) applyStimulus(16'h0000, "key5rel");

    repeat (2) applyStimulus(16'h8000, "bounceD1");
    applyStimulus(16'h0000, "bounceGap");
    repeat (4) applyStimulus(16'h8000, "bounceD2");
    repeat (3) applyStimulus(16'h0000, "bounceRel");

    repeat (10) applyStimulus(16'h0003, "multi");
    applyStimulus(16'h0000, "multiRel");

    repeat (3) applyStimulus(16'h0008, "keyA");
    repeat (3) applyStimulus(16'h1000, "swap0");
    repeat (3) applyStimulus(16'h0000, "swapRel");
    repeat (3) applyStimulus(16'h1000, "key0");
    repeat (3) applyStimulus(16'h0000, "key0Rel");

    applyStimulus(16'h0100, "key7f1");
    resetMid(16'h0100, 20);
    repeat (3) applyStimulus(16'h0100, "key7post");
    repeat (3) applyStimulus(16'h0000, "key7Rel");

    repeat (25) begin
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, 5);
      rmask = '0;
      if (kind >= 4 && kind <= 8) begin
        rmask[$urandom_range(0, 15)] = 1'b1;
      end else if (kind == 9) begin
        b1 = $urandom_range(0, 15);
        b2 = (b1 + $urandom_range(1, 15)) % 16;
        rmask[b1] = 1'b1;
        rmask[b2] = 1'b1;
      end
      repeat (len) applyStimulus(rmask, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
